// File: rtl/imem_boot_ctrl_if.sv
// imem_boot_ctrl_if: boot stream handshake plus instruction-memory write port.
// master = stream source / memory side, slave = boot controller.
interface imem_boot_ctrl_if #(
    parameter int unsigned AW = 10
);
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_din;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_din
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output imem_we,
        output imem_addr,
        output imem_din
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: holds the core in reset, loads a length-prefixed word stream
// into instruction memory from address 0, then releases core reset after a
// settle delay. Define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR
// checksum beat after the image words.
module imem_boot_ctrl #(
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned AW            = 10,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_req,
    imem_boot_ctrl_if.slave bus,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            err
);
    // Length/count need one extra bit so that L == DEPTH is representable.
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [2:0] S_HDR    = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd2;
`endif
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]    r_state,    w_state_nxt;
    logic [CW-1:0] r_len,      w_len_nxt;
    logic [CW-1:0] r_count,    w_count_nxt;
    logic [SW-1:0] r_settle,   w_settle_nxt;
    logic          r_we,       w_we_nxt;
    logic [AW-1:0] r_addr,     w_addr_nxt;
    logic [31:0]   r_din,      w_din_nxt;
    logic          r_core_rst, w_core_rst_nxt;
    logic          r_busy,     w_busy_nxt;
    logic          r_done,     w_done_nxt;
    logic          r_err,      w_err_nxt;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0]   r_csum,     w_csum_nxt;
`endif

    logic w_ready;
    logic w_xfer;

    // Stream is accepted only in the loading states, and never alongside load_req.
    always_comb begin
        w_ready = 1'b0;
        if ((r_state == S_HDR) || (r_state == S_LOAD)
`ifdef IMEM_BOOT_CHECKSUM_EN
            || (r_state == S_CSUM)
`endif
           ) begin
            w_ready = !load_req;
        end
        w_xfer = bus.s_valid && w_ready;
    end

    assign bus.s_ready   = w_ready;
    assign bus.imem_we   = r_we;
    assign bus.imem_addr = r_addr;
    assign bus.imem_din  = r_din;
    assign core_rst      = r_core_rst;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

    // Next-state, counters, write port and status outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_count_nxt  = r_count;
        w_settle_nxt = r_settle;
        w_we_nxt     = 1'b0;
        w_addr_nxt   = r_addr;
        w_din_nxt    = r_din;
`ifdef IMEM_BOOT_CHECKSUM_EN
        w_csum_nxt   = r_csum;
`endif
        if (load_req) begin
            // A write registered last cycle is already on the port and completes.
            w_state_nxt  = S_HDR;
            w_len_nxt    = '0;
            w_count_nxt  = '0;
            w_settle_nxt = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            w_csum_nxt   = '0;
`endif
        end else begin
            case (r_state)
                S_HDR: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    w_csum_nxt = '0;
`endif
                    if (w_xfer) begin
                        if ((bus.s_data == 32'd0) || (bus.s_data > 32'(DEPTH))) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_len_nxt   = CW'(bus.s_data);
                            w_count_nxt = '0;
                            w_state_nxt = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = r_count[AW-1:0];
                        w_din_nxt   = bus.s_data;
                        w_count_nxt = r_count + CW'(1);
`ifdef IMEM_BOOT_CHECKSUM_EN
                        w_csum_nxt  = r_csum ^ bus.s_data;
`endif
                        if (r_count == (r_len - CW'(1))) begin
                            w_settle_nxt = SW'(SETTLE_CYCLES);
`ifdef IMEM_BOOT_CHECKSUM_EN
                            w_state_nxt  = S_CSUM;
`else
                            w_state_nxt  = S_SETTLE;
`endif
                        end
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                S_CSUM: begin
                    if (w_xfer) begin
                        if (bus.s_data == r_csum) begin
                            w_settle_nxt = SW'(SETTLE_CYCLES);
                            w_state_nxt  = S_SETTLE;
                        end else begin
                            w_state_nxt  = S_ERR;
                        end
                    end
                end
`endif
                S_SETTLE: begin
                    if (r_settle == SW'(1)) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_settle_nxt = r_settle - SW'(1);
                    end
                end
                S_RUN, S_ERR: begin
                end
                default: begin
                    w_state_nxt = S_HDR;
                end
            endcase
        end

        // Status follows the state being entered so it changes on that edge.
        w_core_rst_nxt = (w_state_nxt != S_RUN);
        w_done_nxt     = (w_state_nxt == S_RUN);
        w_err_nxt      = (w_state_nxt == S_ERR);
        w_busy_nxt     = (w_state_nxt != S_RUN) && (w_state_nxt != S_ERR);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_HDR;
            r_len      <= '0;
            r_count    <= '0;
            r_settle   <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_count    <= w_count_nxt;
            r_settle   <= w_settle_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_din      <= w_din_nxt;
            r_core_rst <= w_core_rst_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
`ifdef IMEM_BOOT_CHECKSUM_EN
            r_csum     <= w_csum_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: scenario tasks against a queue-based image/timing model.
`timescale 1ns/1ps
module tb_imem_boot_ctrl;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned AW     = 10;
    localparam int unsigned SETTLE = 4;

    logic clk = 1'b0;
    logic rst;
    logic load_req;
    logic core_rst, busy, done, err;

    imem_boot_ctrl_if #(.AW(AW)) bus();

    imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW), .SETTLE_CYCLES(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .bus      (bus),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Image model: header then words; the cycle each beat was accepted.
    logic [31:0]   tb_words[$];
    int            acc_cyc[$];
    bit            drv_timeout;
    // Observed memory writes.
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            wr_cyc[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_din);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic clear_obs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    endtask

    // Append the XOR checksum of the data words when the feature is built in.
    task automatic add_csum();
`ifdef IMEM_BOOT_CHECKSUM_EN
        logic [31:0] x;
        x = '0;
        for (int i = 1; i < tb_words.size(); i++) x ^= tb_words[i];
        tb_words.push_back(x);
`endif
    endtask

    task automatic make_image(input int len);
        tb_words.delete();
        tb_words.push_back(32'(len));
        for (int i = 0; i < len; i++) tb_words.push_back($urandom);
        add_csum();
    endtask

    // Present tb_words in order; gap_pct is the chance of idling a cycle.
    task automatic drive_stream(input int gap_pct);
        int  waited;
        bit  took;
        acc_cyc.delete();
        drv_timeout = 1'b0;
        foreach (tb_words[i]) begin
            waited = 0;
            took   = 1'b0;
            while (!took) begin
                if (int'($urandom_range(99)) < gap_pct) begin
                    bus.s_valid = 1'b0;
                    bus.s_data  = $urandom;
                end else begin
                    bus.s_valid = 1'b1;
                    bus.s_data  = tb_words[i];
                end
                #1;
                if (bus.s_valid && bus.s_ready === 1'b1) begin
                    took = 1'b1;
                    acc_cyc.push_back(cyc);
                end
                @(negedge clk);
                waited++;
                if (waited > 64) begin
                    drv_timeout = 1'b1;
                    took = 1'b1;
                end
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_release(output int rel);
        for (int i = 0; i < 200; i++) begin
            if (core_rst === 1'b0) begin
                rel = cyc;
                return;
            end
            @(negedge clk);
        end
        rel = -1;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_req = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.s_ready, bus.imem_we, core_rst, busy, done, err} !== 6'b101100) begin
            n_errors++;
            $display("FAIL reset_flags: got rdy/we/crst/busy/done/err=%b, expected 101100",
                     {bus.s_ready, bus.imem_we, core_rst, busy, done, err});
        end
        n_checks++;
        if (bus.imem_addr !== '0 || bus.imem_din !== '0) begin
            n_errors++;
            $display("FAIL reset_port: got addr %0d din %h, expected 0 0", bus.imem_addr, bus.imem_din);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int rel, L;
        tb_words = '{32'd3, 32'h0062a023, 32'h0002a383, 32'h002384b3};
        add_csum();
        L = 3;
        clear_obs();
        drive_stream(0);
        wait_release(rel);
        n_checks++;
        if (drv_timeout !== 1'b0 || acc_cyc.size() !== tb_words.size()) begin
            n_errors++; $display("FAIL b2b_accept: got %0d accepts, expected %0d", acc_cyc.size(), tb_words.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_checks++;
            if (acc_cyc[i] !== acc_cyc[0] + i) begin
                n_errors++; $display("FAIL b2b_gapless[%0d]: got cycle %0d, expected %0d", i, acc_cyc[i], acc_cyc[0] + i);
            end
        end
        n_checks++;
        if (wr_addr.size() !== L) begin
            n_errors++; $display("FAIL b2b_nwrites: got %0d, expected %0d", wr_addr.size(), L);
        end
        for (int i = 0; i < L && i < wr_addr.size(); i++) begin
            n_checks++;
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== tb_words[i+1] || wr_cyc[i] !== acc_cyc[i+1] + 1) begin
                n_errors++;
                $display("FAIL b2b_write[%0d]: got addr %0d data %h cyc %0d, expected addr %0d data %h cyc %0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], i, tb_words[i+1], acc_cyc[i+1] + 1);
            end
        end
        n_checks++;
        if (rel !== acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE)) begin
            n_errors++; $display("FAIL b2b_release: got cycle %0d, expected %0d", rel, acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE));
        end
        n_checks++;
        if ({done, busy, err, core_rst, bus.s_ready} !== 5'b10000) begin
            n_errors++; $display("FAIL b2b_run: got done/busy/err/crst/rdy=%b, expected 10000", {done, busy, err, core_rst, bus.s_ready});
        end
    endtask

    task automatic test_reload_from_run();
        int rel, L;
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++; $display("FAIL reload_pre: got done=%b, expected 1", done);
        end
        load_req = 1'b1; bus.s_valid = 1'b1; bus.s_data = 32'd1;
        #1;
        n_checks++;
        if (bus.s_ready !== 1'b0) begin
            n_errors++; $display("FAIL reload_ready_during_req: got %b, expected 0", bus.s_ready);
        end
        @(negedge clk);
        load_req = 1'b0; bus.s_valid = 1'b0;
        #1;
        n_checks++;
        if ({core_rst, done, busy, err, bus.s_ready} !== 5'b10101) begin
            n_errors++; $display("FAIL reload_hdr: got crst/done/busy/err/rdy=%b, expected 10101", {core_rst, done, busy, err, bus.s_ready});
        end
        @(negedge clk);
        tb_words = '{32'd1, 32'h00000013};
        add_csum();
        L = 1;
        clear_obs();
        drive_stream(0);
        wait_release(rel);
        n_checks++;
        if (drv_timeout !== 1'b0 || wr_addr.size() !== L) begin
            n_errors++; $display("FAIL reload_nwrites: got %0d (timeout %b), expected %0d", wr_addr.size(), drv_timeout, L);
        end
        for (int i = 0; i < L && i < wr_addr.size(); i++) begin
            n_checks++;
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== tb_words[i+1] || wr_cyc[i] !== acc_cyc[i+1] + 1) begin
                n_errors++;
                $display("FAIL reload_write[%0d]: got addr %0d data %h cyc %0d, expected addr %0d data %h cyc %0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], i, tb_words[i+1], acc_cyc[i+1] + 1);
            end
        end
        n_checks++;
        if (rel !== acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE) || done !== 1'b1) begin
            n_errors++; $display("FAIL reload_release: got cycle %0d done %b, expected %0d done 1", rel, done, acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE));
        end
    endtask

    task automatic test_gaps();
        int rel, L;
        pulse_load_req();
        tb_words = '{32'd3, 32'h0062a023, 32'h0002a383, 32'h002384b3};
        add_csum();
        L = 3;
        clear_obs();
        drive_stream(60);
        wait_release(rel);
        n_checks++;
        if (drv_timeout !== 1'b0 || wr_addr.size() !== L) begin
            n_errors++; $display("FAIL gaps_nwrites: got %0d (timeout %b), expected %0d", wr_addr.size(), drv_timeout, L);
        end
        for (int i = 0; i < L && i < wr_addr.size(); i++) begin
            n_checks++;
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== tb_words[i+1] || wr_cyc[i] !== acc_cyc[i+1] + 1) begin
                n_errors++;
                $display("FAIL gaps_write[%0d]: got addr %0d data %h cyc %0d, expected addr %0d data %h cyc %0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], i, tb_words[i+1], acc_cyc[i+1] + 1);
            end
        end
        n_checks++;
        if (rel !== acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE)) begin
            n_errors++; $display("FAIL gaps_release: got cycle %0d, expected %0d", rel, acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE));
        end
    endtask

    task automatic test_bad_header();
        logic [31:0] hdrs[3];
        hdrs[0] = 32'd0;
        hdrs[1] = 32'(DEPTH + 1);
        hdrs[2] = 32'(DEPTH + 1) + ($urandom & 32'h7fff_ffff);
        for (int k = 0; k < 3; k++) begin
            pulse_load_req();
            tb_words = '{hdrs[k]};
            clear_obs();
            drive_stream(0);
            n_checks++;
            if ({err, core_rst, bus.s_ready, busy, done} !== 5'b11000 || wr_addr.size() !== 0) begin
                n_errors++;
                $display("FAIL badhdr_err[%h]: got err/crst/rdy/busy/done=%b writes %0d, expected 11000 writes 0",
                         hdrs[k], {err, core_rst, bus.s_ready, busy, done}, wr_addr.size());
            end
            repeat (3) @(negedge clk);
            n_checks++;
            if (err !== 1'b1) begin
                n_errors++; $display("FAIL badhdr_sticky: got err=%b, expected 1", err);
            end
            pulse_load_req();
            #1;
            n_checks++;
            if ({err, bus.s_ready, busy, core_rst} !== 4'b0111) begin
                n_errors++; $display("FAIL badhdr_clear: got err/rdy/busy/crst=%b, expected 0111", {err, bus.s_ready, busy, core_rst});
            end
            @(negedge clk);
        end
        // In HDR, a beat alongside load_req must be refused.
        load_req = 1'b1; bus.s_valid = 1'b1; bus.s_data = 32'd0;
        #1;
        n_checks++;
        if (bus.s_ready !== 1'b0) begin
            n_errors++; $display("FAIL hdr_req_ready: got %b, expected 0", bus.s_ready);
        end
        @(negedge clk);
        load_req = 1'b0; bus.s_valid = 1'b0;
        #1;
        n_checks++;
        if ({err, bus.s_ready} !== 2'b01) begin
            n_errors++; $display("FAIL hdr_req_refused: got err/rdy=%b, expected 01", {err, bus.s_ready});
        end
        @(negedge clk);
    endtask

    task automatic test_rst_midload();
        int rel, L;
        tb_words = '{32'd5, $urandom, $urandom};
        clear_obs();
        drive_stream(0);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.s_ready, bus.imem_we, core_rst, busy, done, err} !== 6'b101100 || bus.imem_addr !== '0 || bus.imem_din !== '0) begin
            n_errors++;
            $display("FAIL midrst_values: got rdy/we/crst/busy/done/err=%b addr %0d din %h, expected 101100 0 0",
                     {bus.s_ready, bus.imem_we, core_rst, busy, done, err}, bus.imem_addr, bus.imem_din);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        make_image(2);
        L = 2;
        clear_obs();
        drive_stream(0);
        wait_release(rel);
        n_checks++;
        if (drv_timeout !== 1'b0 || wr_addr.size() !== L) begin
            n_errors++; $display("FAIL midrst_nwrites: got %0d (timeout %b), expected %0d", wr_addr.size(), drv_timeout, L);
        end
        for (int i = 0; i < L && i < wr_addr.size(); i++) begin
            n_checks++;
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== tb_words[i+1] || wr_cyc[i] !== acc_cyc[i+1] + 1) begin
                n_errors++;
                $display("FAIL midrst_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, wr_addr[i], wr_data[i], i, tb_words[i+1]);
            end
        end
        n_checks++;
        if (rel !== acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE) || done !== 1'b1) begin
            n_errors++; $display("FAIL midrst_release: got cycle %0d done %b, expected %0d done 1", rel, done, acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE));
        end
    endtask

    // Random lengths and gaps; also used for the full-depth boundary.
    task automatic test_random_loads(input int iters, input int fixed_len);
        int rel, L, gap;
        for (int it = 0; it < iters; it++) begin
            pulse_load_req();
            L   = (fixed_len > 0) ? fixed_len : int'($urandom_range(12, 1));
            gap = (fixed_len > 0) ? 0 : int'($urandom_range(70));
            make_image(L);
            clear_obs();
            drive_stream(gap);
            wait_release(rel);
            n_checks++;
            if (drv_timeout !== 1'b0 || wr_addr.size() !== L) begin
                n_errors++; $display("FAIL rand_nwrites[L=%0d]: got %0d (timeout %b), expected %0d", L, wr_addr.size(), drv_timeout, L);
            end
            for (int i = 0; i < L && i < wr_addr.size(); i++) begin
                n_checks++;
                if (wr_addr[i] !== AW'(i) || wr_data[i] !== tb_words[i+1] || wr_cyc[i] !== acc_cyc[i+1] + 1) begin
                    n_errors++;
                    $display("FAIL rand_write[%0d]: got addr %0d data %h cyc %0d, expected addr %0d data %h cyc %0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i], i, tb_words[i+1], acc_cyc[i+1] + 1);
                end
            end
            n_checks++;
            if (rel !== acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE)) begin
                n_errors++; $display("FAIL rand_release[L=%0d]: got cycle %0d, expected %0d", L, rel, acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE));
            end
            n_checks++;
            if ({done, busy, err, core_rst, bus.s_ready} !== 5'b10000) begin
                n_errors++; $display("FAIL rand_run: got done/busy/err/crst/rdy=%b, expected 10000", {done, busy, err, core_rst, bus.s_ready});
            end
        end
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        int rel;
        pulse_load_req();
        tb_words = '{32'd2, 32'h1, 32'h2, 32'h3};
        clear_obs();
        drive_stream(0);
        wait_release(rel);
        n_checks++;
        if (rel !== acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE) || done !== 1'b1 || wr_addr.size() !== 2) begin
            n_errors++; $display("FAIL csum_good: got release %0d done %b writes %0d, expected %0d 1 2",
                                 rel, done, wr_addr.size(), acc_cyc[acc_cyc.size()-1] + 1 + int'(SETTLE));
        end
        pulse_load_req();
        tb_words = '{32'd2, 32'h1, 32'h2, 32'h4};
        clear_obs();
        drive_stream(0);
        n_checks++;
        if ({err, core_rst, done, bus.s_ready} !== 4'b1100 || wr_addr.size() !== 2) begin
            n_errors++; $display("FAIL csum_bad: got err/crst/done/rdy=%b writes %0d, expected 1100 writes 2",
                                 {err, core_rst, done, bus.s_ready}, wr_addr.size());
        end
        repeat (SETTLE + 2) @(negedge clk);
        n_checks++;
        if (core_rst !== 1'b1 || err !== 1'b1) begin
            n_errors++; $display("FAIL csum_hold: got crst %b err %b, expected 1 1", core_rst, err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_reload_from_run();
        test_gaps();
        test_bad_header();
        test_rst_midload();
        test_random_loads(8, 0);
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_random_loads(1, int'(DEPTH));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
